rvx_core_trap_ctrl: RTL
=======================

// Module: rvx_core_trap_ctrl
// PURPOSE
//  Parametrised trap controller for the RVX core stage 1; decides, prioritises and sequences machine-mode traps.
//  Synchronises and latches interrupt lines (software, timer, NUM_EXT_IRQ external), encodes mcause, computes the trap target.
//  Tracks handler nesting depth and flags a double fault.
//  Consumed by the CSR file (mcause/mepc/mip writes) and the fetch redirect logic.
// PARAMETERS
//  NUM_EXT_IRQ    4      number of external interrupt lines, 1..16
//  EXT_IRQ_EDGE   4'b0   per-line mode mask: 1 = rising-edge latched, 0 = level
//  SYNC_STAGES    2      synchroniser flops on each async irq line, 2..3
//  MAX_NEST       2      trap nesting depth allowed before double fault, 1..7
// PORTS
//  clock                              in   1    core clock
//  reset_n                            in   1    asynchronous active-low reset
//  stall_s1                           in   1    stage 1 stalled; no trap may commit
//  ecall_s1, ebreak_s1                in   1    synchronous exception flags
//  illegal_instruction_s1             in   1    illegal instruction
//  misaligned_instruction_address_s1  in   1    misaligned fetch target
//  misaligned_load_s1                 in   1    misaligned load address
//  misaligned_store_s1                in   1    misaligned store address
//  mret_s1                            in   1    mret retiring this cycle
//  global_interrupt_enable_s1         in   1    mstatus.MIE
//  mie_s1                             in   3    {MEIE,MTIE,MSIE}
//  mtvec_s1                           in   32   trap vector CSR
//  irq_software, irq_timer            in   1    async interrupt requests
//  irq_external                       in   NUM_EXT_IRQ  async external requests
//  irq_ext_claim_s1                   in   1    handler claims irq_ext_id (clears edge pending)
//  take_trap_s1                       out  1    trap commits this cycle
//  trap_cause_s1                      out  32   mcause value {interrupt, 27'b0, code}
//  trap_target_s1                     out  32   next PC on trap
//  mip_s1                             out  3    {MEIP,MTIP,MSIP}
//  irq_ext_id                         out  4    lowest-index pending external line
//  nest_depth                         out  3    current handler depth
//  double_fault                       out  1    sticky; exception at MAX_NEST depth
// BEHAVIOUR
//  Reset: all sync flops, edge pending regs and nest_depth = 0; double_fault = 0; FSM = RUN.
//  Reset is async assert, sync deassert; reset mid-handler discards all pending and depth.
//  Outputs while in reset: take_trap_s1 = 0, trap_cause_s1 = 0, mip_s1 = 0.
//  IRQ path: SYNC_STAGES flops, then:
//   - Level line: pending = synced value.
//   - Edge line: set on synced 0->1; cleared on claim of that id. Set wins over clear in the same cycle.
//  Interrupt latency: input change to mip_s1 change = SYNC_STAGES+1 cycles.
//  MEIP = OR of pending external lines; irq_ext_id = lowest pending index, 0 if none.
//  irq_ok = global_interrupt_enable_s1 & |(mip_s1 & mie_s1).
//  Priority, highest first:
//   - Interrupts: MEI(11), MSI(3), MTI(7).
//   - Exceptions: misaligned instruction address(0), illegal(2), ebreak(3), ecall(11), misaligned load(4), misaligned store(6).
//   - An interrupt pre-empts a simultaneous exception; the instruction re-executes after mret.
//  take_trap_s1 = (irq_ok | any exception) & ~stall_s1 & ~double_fault; combinational from registered pending.
//  FSM RUN/HANDLER:
//   - take_trap in RUN: go to HANDLER, depth = 1.
//   - take_trap in HANDLER: depth+1.
//   - mret_s1 (not stalled): depth-1; return to RUN at 0.
//   - mret in RUN: ignored; depth saturates at 0.
//   - Exception with depth == MAX_NEST: no trap; double_fault set and held until reset.
//   - take_trap and mret in the same cycle: trap wins and mret is dropped (a trapping instruction never retires).
//  trap_target_s1 = {mtvec_s1[31:2], 2'b00}.
// CONFIGURATION
//  RVX_TRAP_VECTORED_EN defined: mtvec_s1[1:0] == 2'b01 with an interrupt trap gives target = base + 4*code; exceptions still use base.
//  RVX_TRAP_VECTORED_EN undefined: direct mode only; mtvec_s1[1:0] ignored.
// STRUCTURE
//  rvx_constants.vh: cause codes (CAUSE_*), mip bit indices, FSM state encodings.
//  Sub-module rvx_core_irq_sync: one line's synchroniser plus edge/level latch; instantiated NUM_EXT_IRQ+2 times.
// TESTING
//  1. Pulse irq_external[2] (edge) 1 cycle, MEIE=1, MIE=1: take_trap at cycle SYNC_STAGES+1, cause 0x8000000B, id=2; claim clears MEIP.
//  2. Same cycle: illegal + ecall + misaligned_load: cause 0x00000002. Add irq_timer enabled: cause 0x80000007.
//  3. MAX_NEST=2: three nested illegal traps without mret: traps 1-2 taken, third gives double_fault=1 and take_trap=0.
//  4. stall_s1=1 for 3 cycles with a pending trap: take_trap stays 0, fires on the first unstalled cycle, depth=1.
//  5. Vectored build, mtvec=0x100|1, timer irq: target 0x11C; ecall target 0x100. Non-vectored build: both 0x100.
//  6. Assert reset_n low mid-handler (depth=2, edge pending): depth, mip_s1 and double_fault read 0 asynchronously.

Source files
------------

// File: rtl/rvx_core_trap_ctrl_pkg.sv
// Shared definitions for the RVX trap controller: cause codes, mip bit positions,
// handler FSM states and the synchronous exception request bundle.
package rvx_core_trap_ctrl_pkg;

  localparam logic [3:0] CAUSE_MISALIGNED_FETCH = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] CAUSE_MISALIGNED_LOAD  = 4'd4;
  localparam logic [3:0] CAUSE_MISALIGNED_STORE = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
  localparam logic [3:0] CAUSE_M_SW_IRQ         = 4'd3;
  localparam logic [3:0] CAUSE_M_TIMER_IRQ      = 4'd7;
  localparam logic [3:0] CAUSE_M_EXT_IRQ        = 4'd11;

  localparam int MIP_MSI = 0;
  localparam int MIP_MTI = 1;
  localparam int MIP_MEI = 2;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } trap_state_e;

  typedef struct packed {
    logic mis_fetch;
    logic illegal;
    logic ebreak;
    logic ecall;
    logic mis_load;
    logic mis_store;
  } exc_req_t;

  function automatic logic [31:0] mcause(input logic intr, input logic [3:0] code);
    return {intr, 27'b0, code};
  endfunction

endpackage

// File: rtl/rvx_core_irq_sync.sv
// One interrupt line: SYNC_STAGES-deep synchroniser followed by a level or
// rising-edge pending latch (edge pending is cleared by claim; set wins).
module rvx_core_irq_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic irq,
  input  logic claim,
  output logic pending
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   pending_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  if (EDGE) begin : g_edge
    logic synced_q;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        synced_q  <= 1'b0;
        pending_q <= 1'b0;
      end else begin
        synced_q  <= synced;
        pending_q <= (synced & ~synced_q) | (pending_q & ~claim);
      end
    end
  end else begin : g_level
    logic unused_claim;
    assign unused_claim = claim;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) pending_q <= 1'b0;
      else          pending_q <= synced;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/rvx_core_trap_ctrl.sv
// RVX stage-1 machine-mode trap controller: irq latching, cause priority, target, nesting.
// Define RVX_TRAP_VECTORED_EN to enable vectored interrupt targets (mtvec mode 1).
module rvx_core_trap_ctrl
  import rvx_core_trap_ctrl_pkg::*;
#(
  parameter int                     NUM_EXT_IRQ  = 4,
  parameter logic [NUM_EXT_IRQ-1:0] EXT_IRQ_EDGE = '0,
  parameter int                     SYNC_STAGES  = 2,
  parameter int                     MAX_NEST     = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   stall_s1,
  input  logic                   ecall_s1,
  input  logic                   ebreak_s1,
  input  logic                   illegal_instruction_s1,
  input  logic                   misaligned_instruction_address_s1,
  input  logic                   misaligned_load_s1,
  input  logic                   misaligned_store_s1,
  input  logic                   mret_s1,
  input  logic                   global_interrupt_enable_s1,
  input  logic [2:0]             mie_s1,
  input  logic [31:0]            mtvec_s1,
  input  logic                   irq_software,
  input  logic                   irq_timer,
  input  logic [NUM_EXT_IRQ-1:0] irq_external,
  input  logic                   irq_ext_claim_s1,
  output logic                   take_trap_s1,
  output logic [31:0]            trap_cause_s1,
  output logic [31:0]            trap_target_s1,
  output logic [2:0]             mip_s1,
  output logic [3:0]             irq_ext_id,
  output logic [2:0]             nest_depth,
  output logic                   double_fault
);

  localparam int NL = NUM_EXT_IRQ + 2;
  localparam logic [NL-1:0] LINE_EDGE = {EXT_IRQ_EDGE, 2'b00};

  logic [NL-1:0]          irq_raw, line_claim, line_pend;
  logic [NUM_EXT_IRQ-1:0] ext_pend, ext_claim;

  // line 0 = software, line 1 = timer, lines 2.. = external
  assign irq_raw    = {irq_external, irq_timer, irq_software};
  assign line_claim = {ext_claim, 2'b00};

  for (genvar i = 0; i < NL; i++) begin : g_line
    rvx_core_irq_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE(LINE_EDGE[i])) u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .irq     (irq_raw[i]),
      .claim   (line_claim[i]),
      .pending (line_pend[i])
    );
  end

  assign ext_pend = line_pend[NL-1:2];

  always_comb begin
    irq_ext_id = '0;
    for (int i = NUM_EXT_IRQ - 1; i >= 0; i--)
      if (ext_pend[i]) irq_ext_id = 4'(i);
  end

  always_comb begin
    ext_claim = '0;
    for (int i = 0; i < NUM_EXT_IRQ; i++)
      ext_claim[i] = irq_ext_claim_s1 && (irq_ext_id == 4'(i));
  end

  always_comb begin
    mip_s1          = '0;
    mip_s1[MIP_MSI] = line_pend[0];
    mip_s1[MIP_MTI] = line_pend[1];
    mip_s1[MIP_MEI] = |ext_pend;
  end

  exc_req_t    exc;
  trap_state_e state_q, state_d;
  logic [2:0]  depth_q, depth_d;
  logic [2:0]  irq_act;
  logic        at_max, irq_go, exc_any, df_q, df_set;
  logic        cause_intr;
  logic [3:0]  cause_code;

  assign exc = '{mis_fetch: misaligned_instruction_address_s1, illegal: illegal_instruction_s1,
                 ebreak: ebreak_s1, ecall: ecall_s1, mis_load: misaligned_load_s1,
                 mis_store: misaligned_store_s1};

  assign irq_act = mip_s1 & mie_s1;
  assign at_max  = (depth_q == 3'(MAX_NEST));
  // At full depth interrupts are held off so depth can never exceed MAX_NEST.
  assign irq_go  = global_interrupt_enable_s1 & (|irq_act) & ~at_max;
  assign exc_any = (exc != '0);

  always_comb begin
    cause_intr = 1'b0;
    cause_code = '0;
    if (irq_go) begin
      cause_intr = 1'b1;
      if (irq_act[MIP_MEI])      cause_code = CAUSE_M_EXT_IRQ;
      else if (irq_act[MIP_MSI]) cause_code = CAUSE_M_SW_IRQ;
      else                       cause_code = CAUSE_M_TIMER_IRQ;
    end
    else if (exc.mis_fetch) cause_code = CAUSE_MISALIGNED_FETCH;
    else if (exc.illegal)   cause_code = CAUSE_ILLEGAL;
    else if (exc.ebreak)    cause_code = CAUSE_BREAKPOINT;
    else if (exc.ecall)     cause_code = CAUSE_ECALL_M;
    else if (exc.mis_load)  cause_code = CAUSE_MISALIGNED_LOAD;
    else if (exc.mis_store) cause_code = CAUSE_MISALIGNED_STORE;
  end

  assign take_trap_s1  = reset_n & (irq_go | (exc_any & ~at_max)) & ~stall_s1 & ~df_q;
  assign trap_cause_s1 = (reset_n && (irq_go || exc_any)) ? mcause(cause_intr, cause_code) : '0;
  assign df_set        = ~irq_go & exc_any & at_max & ~stall_s1 & ~df_q;

  always_comb begin
    trap_target_s1 = {mtvec_s1[31:2], 2'b00};
`ifdef RVX_TRAP_VECTORED_EN
    if (mtvec_s1[1:0] == 2'b01 && cause_intr)
      trap_target_s1 = {mtvec_s1[31:2], 2'b00} + {26'b0, cause_code, 2'b00};
`endif
  end

`ifdef RVX_TRAP_VECTORED_EN
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_s1[1:0];
`endif

  // A trapping instruction never retires, so a simultaneous mret is dropped.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    if (take_trap_s1) begin
      state_d = ST_HANDLER;
      depth_d = depth_q + 3'd1;
    end else if (mret_s1 && !stall_s1 && state_q == ST_HANDLER) begin
      depth_d = depth_q - 3'd1;
      if (depth_q == 3'd1) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      depth_q <= '0;
      df_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      df_q    <= df_q | df_set;
    end
  end

  assign nest_depth   = depth_q;
  assign double_fault = df_q;

endmodule
